// File: rtl/memory_gateway_pkg.sv
// memory_gateway_pkg: state encoding and default widths shared by the
// memory gateway initiator and its watchdog.
package memory_gateway_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 64;
  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/memory_gateway_watchdog.sv
// memory_gateway_watchdog: cycle counter with synchronous clear and count
// enable; expired is raised while enabled once LIMIT-1 cycles have elapsed.
module memory_gateway_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: default every always_comb output first so no path infers a latch.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // updates from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/memory_gateway_initiator.sv
// memory_gateway_initiator: turns one core-side valid/ready request into a single
// ap_ctrl gateway transaction. Define MEM_GATEWAY_TIMEOUT_EN to add a WAIT watchdog.
module memory_gateway_initiator
  import memory_gateway_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_wen,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  input  logic [63:0]           base_pointer,
  output logic [63:0]           memory_pointer,
  output logic                  ap_start,
  input  logic                  ap_done,
  input  logic                  ap_idle,
  input  logic                  ap_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wen,
  input  logic [DATA_WIDTH-1:0] ap_return,
  output logic                  locked
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;
  logic                  timeout_expired;
  logic                  unused_inputs;

`ifdef MEM_GATEWAY_TIMEOUT_EN
  memory_gateway_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state_q == ISSUE) && ap_idle),
    .enable (state_q == WAIT),
    .expired(timeout_expired)
  );
  assign unused_inputs = ap_ready;
`else
  assign timeout_expired = 1'b0;
  assign unused_inputs   = ap_ready ^ (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wen_d        = wen_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wen_d   = req_wen;
          state_d = ISSUE;
        end
      end
      // The gateway samples ap_start only while it reports idle.
      ISSUE: begin
        if (ap_idle) begin
          state_d = WAIT;
        end
      end
      // ap_return is only meaningful in the ap_done cycle; done beats expiry.
      WAIT: begin
        if (ap_done) begin
          resp_rdata_d = wen_q ? '0 : ap_return;
          resp_error_d = 1'b0;
          state_d      = RESP;
        end else if (timeout_expired) begin
          resp_rdata_d = '0;
          resp_error_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign ap_start       = (state_q == ISSUE);
  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign addr           = addr_q;
  assign wdata          = wdata_q;
  assign wen            = wen_q;
  assign memory_pointer = base_pointer;
  assign locked         = 1'b0;

endmodule

// File: tb/tb_memory_gateway_initiator.sv
// tb_memory_gateway_initiator: drives directed and randomized transactions through
// the initiator against a behavioural gateway and a protocol-level expectation model.
module tb_memory_gateway_initiator;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 16;
`ifdef MEM_GATEWAY_TIMEOUT_EN
  localparam int unsigned TO    = 8;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TO    = 1024;
  localparam bit          TO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_wen;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_error;
  logic [63:0]   base_pointer;
  logic [63:0]   memory_pointer;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          ap_ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wen;
  logic [DW-1:0] ap_return;
  logic          locked;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  memory_gateway_initiator #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wen       (req_wen),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .base_pointer  (base_pointer),
    .memory_pointer(memory_pointer),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .addr          (addr),
    .wdata         (wdata),
    .wen           (wen),
    .ap_return     (ap_return),
    .locked        (locked)
  );

  // Contents of never-written gateway locations.
  function automatic logic [15:0] fill_value(input logic [63:0] a);
    return a[15:0] ^ a[47:32] ^ 16'hA5C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Behavioural gateway: accepts ap_start while idle, answers gw_lat cycles
  // later with one ap_done beat; ap_return is random noise outside that beat.
  int          cyc         = 0;
  int          gw_lat      = 4;
  int          gw_force    = 0;
  bit          gw_spur     = 1'b0;
  bit          gw_busy     = 1'b0;
  int          gw_done_cyc = 0;
  int          gw_accepts  = 0;
  logic [63:0] gw_addr;
  logic [15:0] gw_wdata;
  logic        gw_wen;
  logic [15:0] gw_mem [logic [63:0]];

  initial begin : gateway
    ap_done   = 1'b0;
    ap_idle   = 1'b1;
    ap_ready  = 1'b0;
    ap_return = '0;
    forever begin
      @(negedge clock);
      cyc++;
      ap_done   = 1'b0;
      ap_return = 16'($urandom);
      if (!reset) begin
        gw_busy = 1'b0;
        ap_idle = 1'b1;
      end else begin
        if (gw_busy && cyc > gw_done_cyc) gw_busy = 1'b0;
        if (gw_busy && cyc == gw_done_cyc) begin
          ap_done = 1'b1;
          if (gw_wen) gw_mem[gw_addr] = gw_wdata;
          else ap_return = gw_mem.exists(gw_addr) ? gw_mem[gw_addr] : fill_value(gw_addr);
        end else if (!gw_busy && gw_spur && $urandom_range(1, 0) == 1) begin
          ap_done = 1'b1;
        end
        ap_idle = !gw_busy;
        if (ap_idle && ap_start && gw_force > 0) begin
          ap_idle = 1'b0;
          gw_force--;
        end
        if (ap_idle && ap_start) begin
          gw_busy     = 1'b1;
          gw_accepts++;
          gw_addr     = addr;
          gw_wdata    = wdata;
          gw_wen      = wen;
          gw_done_cyc = cyc + gw_lat + 1;
        end
      end
      ap_ready = ap_done;
    end
  end

  logic [15:0] ref_mem [logic [63:0]];

  // One full request/response; expectations come from the protocol timing:
  // handshake cycle 0, ISSUE from cycle 1, WAIT entered at 2+busy, done at
  // 2+busy+lat, expiry at 2+busy+TO-1, response the cycle after whichever ends WAIT.
  task automatic run_txn(input logic [63:0] a, input logic [15:0] d, input logic w,
                         input int lat, input int busy, input int hold, input bit spur);
    int          cycles, start_cycles, latch_err, hold_err, acc0;
    int          done_c, expire_c, exp_lat;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic [63:0] bp;
    done_c   = 2 + busy + lat;
    expire_c = 2 + busy + int'(TO) - 1;
    if (TO_EN && done_c > expire_c) begin
      exp_lat   = expire_c + 1;
      exp_err   = 1'b1;
      exp_rdata = '0;
    end else begin
      exp_lat   = done_c + 1;
      exp_err   = 1'b0;
      exp_rdata = w ? 16'h0 : (ref_mem.exists(a) ? ref_mem[a] : fill_value(a));
    end
    if (w) ref_mem[a] = d;

    gw_lat   = lat;
    gw_force = busy;
    gw_spur  = spur;
    acc0     = gw_accepts;
    bp       = {$urandom, $urandom};
    base_pointer = bp;
    req_addr   = a;
    req_wdata  = d;
    req_wen    = w;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    cycles = 0;
    while (!req_ready && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("req_ready_idle", req_ready, 1);
    check("memory_pointer", memory_pointer, bp);

    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = 16'($urandom);
    req_wen   = ~w;
    cycles    = 1;
    check("ap_start_issue", ap_start, 1);
    start_cycles = 0;
    latch_err    = 0;
    while (!resp_valid && cycles < 2000) begin
      if (ap_start) start_cycles++;
      if (addr !== a || wdata !== d || wen !== w || req_ready !== 1'b0 || locked !== 1'b0)
        latch_err++;
      @(posedge clock); #1;
      cycles++;
    end
    check("resp_latency", cycles, exp_lat);
    check("ap_start_cycles", start_cycles, busy + 1);
    check("latched_request", latch_err, 0);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_error", resp_error, exp_err);

    hold_err = 0;
    for (int i = 0; i < hold; i++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_error !== exp_err ||
          req_ready !== 1'b0 || ap_start !== 1'b0 || addr !== a || wdata !== d || wen !== w)
        hold_err++;
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    check("resp_hold", hold_err, 0);
    check("resp_cycle", {resp_valid, req_ready}, 2'b10);
    @(posedge clock); #1;
    check("after_resp", {resp_valid, req_ready, ap_start}, 3'b010);
    check("gateway_accepts", gw_accepts - acc0, 1);
  endtask

  initial begin : watchdog_timer
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    logic [63:0] pool [6];
    int          no_resp;
    int          acc0;

    reset        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_wen      = 1'b0;
    resp_ready   = 1'b1;
    base_pointer = 64'h0123_4567_89AB_CDEF;
    gw_mem[64'h10]  = 16'hBEEF;
    ref_mem[64'h10] = 16'hBEEF;
    pool[0] = 64'h10;
    pool[1] = 64'h20;
    pool[2] = 64'h30;
    pool[3] = {$urandom, $urandom};
    pool[4] = {$urandom, $urandom};
    pool[5] = 64'hFFFF_FFFF_FFFF_FFFF;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    check("reset_outputs", {req_ready, ap_start, resp_valid, resp_error, wen, locked}, 6'b100000);
    check("reset_addr", addr, 0);
    check("reset_wdata", wdata, 0);
    check("reset_rdata", resp_rdata, 0);

    run_txn(64'h10, 16'h0000, 1'b0, 4, 0, 0, 1'b0);
    run_txn(64'h20, 16'h1234, 1'b1, 3, 0, 0, 1'b0);
    run_txn(64'h20, 16'h0000, 1'b0, 2, 0, 0, 1'b0);
    run_txn(64'h10, 16'h0000, 1'b0, 4, 0, 10, 1'b0);
    run_txn(64'h20, 16'h0000, 1'b0, 1, 5, 0, 1'b0);
    run_txn(64'h30, 16'hCAFE, 1'b1, 2, 1, 2, 1'b1);
    run_txn(64'h30, 16'h0000, 1'b0, 0, 0, 1, 1'b1);
    run_txn(64'h10, 16'h0000, 1'b0, 7, 0, 0, 1'b0);
    run_txn(64'h10, 16'h0000, 1'b0, 8, 0, 1, 1'b0);

    // Reset while waiting on the gateway abandons the transaction.
    acc0       = gw_accepts;
    gw_lat     = 6;
    gw_force   = 0;
    gw_spur    = 1'b0;
    resp_ready = 1'b1;
    req_addr   = 64'h10;
    req_wen    = 1'b0;
    req_valid  = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("wait_before_reset", {ap_start, resp_valid, req_ready}, 3'b000);
    check("reset_test_accepts", gw_accepts - acc0, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check("post_reset_ctrl", {ap_start, resp_valid, req_ready, resp_error}, 4'b0010);
    check("post_reset_addr", addr, 0);
    check("post_reset_rdata", resp_rdata, 0);
    no_resp = 0;
    repeat (12) begin
      if (resp_valid || ap_start) no_resp++;
      @(posedge clock); #1;
    end
    check("no_resp_after_reset", no_resp, 0);

    for (int n = 0; n < 40; n++) begin
      run_txn(pool[$urandom_range(5, 0)], 16'($urandom), 1'($urandom_range(1, 0)),
              int'($urandom_range(6, 0)), int'($urandom_range(2, 0)),
              int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
